// File: rtl/obstacle_four_motion.sv
// -----------------------------------------------------------------------------
// obstacle_four_motion
//
// Per-frame motion and animation controller for obstacle four. It sits in
// front of the obstacle four sprite source and supplies its origin (x0, y0)
// and 5-bit control word (ctrl).
//
// Once per frame, at the vertical-blank boundary, the controller does three
// things:
//   - scrolls the obstacle left by the latched speed,
//   - wraps it back to the right edge when it would run off the left edge,
//   - steps the sprite animation ID.
//
// Optional feature macro: OBSTACLE_FOUR_MOTION_ANI_EN
//   defined     : the animation frame counter and sid cycling are built in.
//   not defined : no counter is built and ctrl[1:0] is tied to 2'b00.
//
// Parameters
//   H_MAX      : x origin used on reload; the obstacle is fully off-screen
//                to the right at this value.
//   V_MAX      : first non-visible scan line; marks the frame boundary.
//   ANI_FRAMES : frame ticks per animation step (1..255).
//
// Ports
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high reset
//   x, y       in  11  current scan coordinates
//   go         in   1  start or resume motion (level)
//   halt       in   1  freeze motion (level); wins over go
//   speed      in   4  pixels per frame; latched at arm and at wrap
//   lane_y     in  11  obstacle y origin; latched at arm and at wrap
//   color_sel  in   2  body colour; passed straight to ctrl[4:3]
//   x0, y0     out 11  sprite origin (registered)
//   ctrl       out  5  {color_sel, 1'b0, sid[1:0]}
//   busy       out  1  high while armed, running or paused
//   wrap_cnt   out  8  completed passes; saturates at 255
//   frame_tick out  1  one-cycle pulse per frame (registered)
// -----------------------------------------------------------------------------
module obstacle_four_motion #(
    parameter int H_MAX      = 640,
    parameter int V_MAX      = 480,
    parameter int ANI_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        go,
    input  logic        halt,
    input  logic [3:0]  speed,
    input  logic [10:0] lane_y,
    input  logic [1:0]  color_sel,
    output logic [10:0] x0,
    output logic [10:0] y0,
    output logic [4:0]  ctrl,
    output logic        busy,
    output logic [7:0]  wrap_cnt,
    output logic        frame_tick
);

    localparam logic [10:0] H_MAX_L = 11'(H_MAX);
    localparam logic [10:0] V_MAX_L = 11'(V_MAX);

    // An out-of-range animation length elaborates this oddly named block.
    // That makes a bad configuration visible in the elaborated hierarchy.
    if (ANI_FRAMES < 1 || ANI_FRAMES > 255) begin : g_ani_frames_out_of_range
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] x0_q, x0_d;
    logic [10:0] y0_q, y0_d;
    logic [3:0]  spd_q, spd_d;
    logic [7:0]  wrap_q, wrap_d;
    logic        busy_q, busy_d;
    logic        frame_tick_q, frame_tick_d;
    logic        fcond_seen_q, fcond_seen_d;
    logic        fcond;
    logic [1:0]  sid;

    // -------------------------------------------------------------------------
    // Frame boundary detection.
    //
    // The pixel clock may be slower than clk, so fcond can stay high for
    // several cycles. Only its rising edge produces a tick.
    //
    // fcond_seen resets to 1. A boundary that is already in progress when
    // reset is released is therefore treated as already seen, and it does
    // not produce a tick.
    // -------------------------------------------------------------------------
    always_comb begin
        fcond        = (x == 11'd0) && (y == V_MAX_L);
        fcond_seen_d = fcond;
        frame_tick_d = fcond && !fcond_seen_q;
    end

    // -------------------------------------------------------------------------
    // Motion FSM: next state and datapath.
    //
    // Every origin update is gated by frame_tick_q. It therefore lands in
    // the cycle after the tick, while the scan is still in vertical blank.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        spd_d   = spd_q;
        wrap_d  = wrap_q;

        case (state_q)
            ST_IDLE: begin
                x0_d = H_MAX_L;
                if (go && !halt) begin
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                // go and halt are not acted on here; only the first frame
                // boundary moves the FSM on to RUN.
                if (frame_tick_q) begin
                    spd_d   = speed;
                    y0_d    = lane_y;
                    x0_d    = H_MAX_L;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (frame_tick_q) begin
                    // The compare guards the subtraction, so it cannot
                    // underflow. A latched speed of 0 never wraps.
                    if (x0_q >= {7'd0, spd_q}) begin
                        x0_d = x0_q - {7'd0, spd_q};
                    end else begin
                        x0_d  = H_MAX_L;
                        spd_d = speed;
                        y0_d  = lane_y;
                        if (wrap_q != 8'hFF) begin
                            wrap_d = wrap_q + 8'd1;
                        end
                    end
                end
                // When halt and the tick arrive together, the tick update
                // above is still applied before the FSM moves to PAUSE.
                if (halt) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (go && !halt) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            x0_q         <= H_MAX_L;
            y0_q         <= 11'd0;
            spd_q        <= 4'd0;
            wrap_q       <= 8'd0;
            busy_q       <= 1'b0;
            frame_tick_q <= 1'b0;
            fcond_seen_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            spd_q        <= spd_d;
            wrap_q       <= wrap_d;
            busy_q       <= busy_d;
            frame_tick_q <= frame_tick_d;
            fcond_seen_q <= fcond_seen_d;
        end
    end

    // -------------------------------------------------------------------------
    // Animation.
    //
    // The frame counter advances only on ticks seen in RUN. When it reaches
    // ANI_FRAMES-1 it clears and sid steps to the next value (mod 4).
    // Entering ARM from IDLE restarts the sequence.
    // -------------------------------------------------------------------------
`ifdef OBSTACLE_FOUR_MOTION_ANI_EN
    localparam logic [7:0] ANI_LAST = 8'(ANI_FRAMES - 1);

    logic [7:0] ani_cnt_q, ani_cnt_d;
    logic [1:0] sid_q, sid_d;

    always_comb begin
        ani_cnt_d = ani_cnt_q;
        sid_d     = sid_q;
        if (state_q == ST_IDLE && state_d == ST_ARM) begin
            ani_cnt_d = 8'd0;
            sid_d     = 2'd0;
        end else if (state_q == ST_RUN && frame_tick_q) begin
            if (ani_cnt_q == ANI_LAST) begin
                ani_cnt_d = 8'd0;
                sid_d     = sid_q + 2'd1;
            end else begin
                ani_cnt_d = ani_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ani_cnt_q <= 8'd0;
            sid_q     <= 2'd0;
        end else begin
            ani_cnt_q <= ani_cnt_d;
            sid_q     <= sid_d;
        end
    end

    assign sid = sid_q;
`else
    assign sid = 2'b00;
`endif

    // -------------------------------------------------------------------------
    // Outputs. ctrl[2] is the sprite auto bit and is never set here.
    // -------------------------------------------------------------------------
    assign x0         = x0_q;
    assign y0         = y0_q;
    assign ctrl       = {color_sel, 1'b0, sid};
    assign busy       = busy_q;
    assign wrap_cnt   = wrap_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_obstacle_four_motion.sv
// -----------------------------------------------------------------------------
// tb_obstacle_four_motion
//
// Drives obstacle_four_motion with two kinds of raster:
//   - a real raster at 4 clocks per pixel,
//   - short synthetic frames (random blanking, then a frame-boundary burst).
//
// A behavioural reference model thinks in frames and modes. A compare
// process checks every DUT output against that model on each falling edge.
// Directed scenarios add hand-computed literal expectations, followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_obstacle_four_motion;

  localparam int H_MAX      = 640;
  localparam int V_MAX      = 6;
  localparam int ANI_FRAMES = 2;
  localparam int H_TOT      = 8;
  localparam int V_TOT      = V_MAX + 2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] x = 11'd1;
  logic [10:0] y = 11'd0;
  logic        go = 1'b0;
  logic        halt = 1'b0;
  logic [3:0]  speed = 4'd0;
  logic [10:0] lane_y = 11'd0;
  logic [1:0]  color_sel = 2'd0;
  logic [10:0] x0;
  logic [10:0] y0;
  logic [4:0]  ctrl;
  logic        busy;
  logic [7:0]  wrap_cnt;
  logic        frame_tick;

  always #5 clk = ~clk;

  obstacle_four_motion #(
    .H_MAX(H_MAX),
    .V_MAX(V_MAX),
    .ANI_FRAMES(ANI_FRAMES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .x(x),
    .y(y),
    .go(go),
    .halt(halt),
    .speed(speed),
    .lane_y(lane_y),
    .color_sel(color_sel),
    .x0(x0),
    .y0(y0),
    .ctrl(ctrl),
    .busy(busy),
    .wrap_cnt(wrap_cnt),
    .frame_tick(frame_tick)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  int n_ticks = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model.
  //
  // The model holds a mode, the latched speed, and a count of frames since
  // the last animation step. A frame event is noticed one cycle after the
  // boundary starts, and its effect becomes visible one cycle after that.
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_PAUSE = 3;

  int m_mode = M_IDLE;
  int m_x0 = H_MAX;
  int m_y0 = 0;
  int m_spd = 0;
  int m_wrap = 0;
  int m_sid = 0;
  int m_frames = 0;
  bit m_busy = 1'b0;
  bit m_tick = 1'b0;
  bit m_in_boundary = 1'b1;
  bit m_fc;
  bit m_event;

  function automatic void model_run_frame();
    if (m_x0 >= m_spd) begin
      m_x0 = m_x0 - m_spd;
    end else begin
      m_x0 = H_MAX;
      if (m_wrap < 255) m_wrap = m_wrap + 1;
      m_spd = int'(speed);
      m_y0 = int'(lane_y);
    end
`ifdef OBSTACLE_FOUR_MOTION_ANI_EN
    m_frames = m_frames + 1;
    if (m_frames == ANI_FRAMES) begin
      m_frames = 0;
      m_sid = (m_sid + 1) % 4;
    end
`endif
  endfunction

  always @(posedge clk) begin
    m_fc = (x == 11'd0) && (y == 11'(V_MAX));
    if (reset) begin
      m_mode = M_IDLE;
      m_x0 = H_MAX;
      m_y0 = 0;
      m_spd = 0;
      m_wrap = 0;
      m_sid = 0;
      m_frames = 0;
      m_busy = 1'b0;
      m_tick = 1'b0;
      m_in_boundary = 1'b1;
    end else begin
      m_event = m_tick;
      m_tick = m_fc && !m_in_boundary;
      m_in_boundary = m_fc;
      case (m_mode)
        M_IDLE: begin
          if (go && !halt) begin
            m_mode = M_ARM;
            m_sid = 0;
            m_frames = 0;
          end
        end
        M_ARM: begin
          if (m_event) begin
            m_spd = int'(speed);
            m_y0 = int'(lane_y);
            m_x0 = H_MAX;
            m_mode = M_RUN;
          end
        end
        M_RUN: begin
          if (m_event) model_run_frame();
          if (halt) m_mode = M_PAUSE;
        end
        default: begin
          if (go && !halt) m_mode = M_RUN;
        end
      endcase
      m_busy = (m_mode != M_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process and tick monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("x0", 32'(x0), 32'(m_x0));
      chk("y0", 32'(y0), 32'(m_y0));
      chk("ctrl", 32'(ctrl), 32'(int'(color_sel) * 8 + m_sid));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("wrap_cnt", 32'(wrap_cnt), 32'(m_wrap));
      chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    end
    if (frame_tick === 1'b1) n_ticks++;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    cyc();
    go = 1'b0;
  endtask

  // Full raster scan at a given number of clocks per pixel.
  task automatic scan_frame(input int cpp);
    for (int yy = 0; yy < V_TOT; yy++) begin
      for (int xx = 0; xx < H_TOT; xx++) begin
        x = 11'(xx);
        y = 11'(yy);
        repeat (cpp) cyc();
      end
    end
  endtask

  // Short synthetic frame: random non-boundary cycles, then a boundary burst
  // of 1..3 cycles, then two cycles off the boundary. That is enough time
  // for the tick and the update that follows it.
  task automatic fast_frame();
    x = 11'($urandom_range(0, 50));
    y = 11'($urandom_range(0, V_MAX - 1));
    repeat ($urandom_range(1, 4)) cyc();
    x = 11'd0;
    y = 11'(V_MAX);
    repeat ($urandom_range(1, 3)) cyc();
    x = 11'd3;
    y = 11'(V_MAX);
    repeat (2) cyc();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int snap;
  int ani_tab[8];

  initial begin
`ifdef OBSTACLE_FOUR_MOTION_ANI_EN
    ani_tab = '{0, 1, 1, 2, 2, 3, 3, 0};
`else
    ani_tab = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif

    // Reset state.
    do_reset();
    chk_en = 1'b1;
    chk("rst_x0", 32'(x0), 32'd640);
    chk("rst_y0", 32'(y0), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wrap", 32'(wrap_cnt), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);

    // Three full frames at 4 clocks per pixel with no go.
    n_ticks = 0;
    repeat (3) scan_frame(4);
    chk("idle_ticks", 32'(n_ticks), 32'd3);
    chk("idle_x0", 32'(x0), 32'd640);
    chk("idle_busy", 32'(busy), 32'd0);

    // Arm with speed 5 at lane 200, then three run frames.
    speed = 4'd5;
    lane_y = 11'd200;
    pulse_go();
    chk("arm_busy", 32'(busy), 32'd1);
    fast_frame();
    chk("arm_x0", 32'(x0), 32'd640);
    chk("arm_y0", 32'(y0), 32'd200);
    repeat (3) fast_frame();
    chk("run3_x0", 32'(x0), 32'd625);

    // Speed 15 from 640: 42 frames reach 10, and the next frame wraps.
    do_reset();
    speed = 4'd15;
    lane_y = 11'd50;
    pulse_go();
    fast_frame();
    repeat (42) fast_frame();
    chk("pre_wrap_x0", 32'(x0), 32'd10);
    speed = 4'd3;
    lane_y = 11'd77;
    fast_frame();
    chk("wrap_x0", 32'(x0), 32'd640);
    chk("wrap_cnt1", 32'(wrap_cnt), 32'd1);
    chk("wrap_y0", 32'(y0), 32'd77);
    fast_frame();
    chk("post_wrap_x0", 32'(x0), 32'd637);

    // halt together with go pauses; the origin holds across two frames.
    halt = 1'b1;
    go = 1'b1;
    cyc();
    go = 1'b0;
    repeat (2) fast_frame();
    chk("pause_x0", 32'(x0), 32'd637);
    chk("pause_busy", 32'(busy), 32'd1);
    halt = 1'b0;
    pulse_go();
    fast_frame();
    chk("resume_x0", 32'(x0), 32'd634);

    // Animation sequence and colour pass-through.
    do_reset();
    color_sel = 2'b10;
    speed = 4'd1;
    lane_y = 11'd10;
    pulse_go();
    fast_frame();
    chk("ani_start", 32'(ctrl), 32'd16);
    for (int i = 0; i < 8; i++) begin
      fast_frame();
      chk("ani_sid", 32'(ctrl[1:0]), 32'(ani_tab[i]));
      chk("ani_color", 32'(ctrl[4:3]), 32'd2);
    end

    // Build up three wraps, then reset while the boundary level is held.
    do_reset();
    color_sel = 2'b01;
    speed = 4'd15;
    pulse_go();
    fast_frame();
    repeat (129) fast_frame();
    chk("wrap_cnt3", 32'(wrap_cnt), 32'd3);
    x = 11'd0;
    y = 11'(V_MAX);
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    snap = n_ticks;
    chk("rr_wrap", 32'(wrap_cnt), 32'd0);
    chk("rr_x0", 32'(x0), 32'd640);
    chk("rr_busy", 32'(busy), 32'd0);
    repeat (4) cyc();
    chk("rr_no_tick", 32'(n_ticks), 32'(snap));
    x = 11'd5;
    cyc();
    fast_frame();
    chk("rr_next_tick", 32'(n_ticks), 32'(snap + 1));

    // Randomized phase.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
      end else begin
        reset = 1'b0;
      end
      go = ($urandom_range(0, 3) == 0);
      halt = ($urandom_range(0, 7) == 0);
      speed = 4'($urandom_range(0, 15));
      lane_y = 11'($urandom_range(0, 2047));
      color_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) cyc();
      end else begin
        fast_frame();
      end
    end
    reset = 1'b0;
    go = 1'b0;
    halt = 1'b0;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/obstacle_four_motion.md
# obstacle_four_motion

Per-frame motion and animation controller for obstacle four. It sits directly upstream of the obstacle four sprite source and drives that block's sprite origin (`x0`, `y0`) and 5-bit sprite control word (`ctrl`). It watches the scan coordinates to find the vertical-blank frame boundary. On each frame it scrolls the obstacle leftward, wraps it back to the right edge, and cycles the sprite animation ID.

## Interface
- `H_MAX`, default 640: reload x origin; at this value the obstacle is fully off-screen right.
- `V_MAX`, default 480: first non-visible scan line; used for frame-boundary detection.
- `ANI_FRAMES`, default 8: frames per animation step (1..255).
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `x`, `y`  in  11 each: current scan coordinates (same values the sprite source sees).
- `go`  in  1: start or resume motion (level, sampled each cycle).
- `halt`  in  1: freeze motion (level, sampled each cycle).
- `speed`  in  4: pixels per frame; latched only at arm and at wrap.
- `lane_y`  in  11: obstacle y origin; latched only at arm and at wrap.
- `color_sel`  in  2: body color; passed to `ctrl[4:3]` combinationally.
- `x0`, `y0`  out  11 each: sprite origin (registered).
- `ctrl`  out  5: `{color_sel, 1'b0, sid[1:0]}`; `ctrl[2]` (auto) is always 0.
- `busy`  out  1: high in ARM, RUN, PAUSE.
- `wrap_cnt`  out  8: number of completed passes; saturates at 255.
- `frame_tick`  out  1: one-cycle pulse per frame (registered).

## Operation
- Frame detect:
  - `fcond` is true when `x==0 && y==V_MAX`.
  - `frame_tick` pulses on the rising edge of `fcond`, so there is exactly one pulse per frame even when the pixel rate is slower than `clk`.
- FSM states: IDLE, ARM, RUN, PAUSE.
  - IDLE: `x0=H_MAX`. On `go && !halt`, go to ARM.
  - ARM: on `frame_tick`, latch `speed` and `lane_y` (`y0<=lane_y`), set `x0<=H_MAX`, and go to RUN.
  - RUN, on each `frame_tick`:
    - If `x0 >= spd_q`: `x0 <= x0 - spd_q`.
    - Otherwise (wrap): `x0<=H_MAX`, `wrap_cnt++` (saturating), re-latch `speed` and `lane_y`.
    - `halt` (with no tick) goes to PAUSE.
  - PAUSE: `x0`, `y0` and `sid` are frozen. On `go && !halt`, return to RUN.
- Priority rules:
  - `halt` beats `go` in the same cycle.
  - In RUN, if `halt` and `frame_tick` coincide, the tick update is applied first, then the FSM moves to PAUSE.
  - `go` while in RUN or ARM is ignored.
  - There is no return to IDLE except via `reset`.
- Latched speed 0: the obstacle is stationary and never wraps. The animation still runs in RUN.
- Arithmetic: 11-bit unsigned. The subtraction never underflows because of the compare.
- Animation:
  - An 8-bit frame counter counts `frame_tick` pulses in RUN only.
  - When the counter reaches `ANI_FRAMES-1`, it clears and `sid` increments mod 4.
  - The frame counter and `sid` clear on entry to ARM.

## Timing
- Reset values: `x0=H_MAX`, `y0=0`, `sid=0` (so `ctrl={color_sel,3'b000}`), `busy=0`, `wrap_cnt=0`, `frame_tick=0`, state IDLE.
- Latency:
  - `frame_tick` is high in the cycle after the rising edge of `fcond`.
  - `x0`, `y0`, `sid` and `wrap_cnt` update in the cycle after `frame_tick`.
  - All updates land during vertical blank, so the sprite never tears.
- `busy` is registered: high in the cycle after the IDLE→ARM transition.
- `reset` mid-frame or mid-RUN: the next cycle shows the reset values. An `fcond` level that is still high does not produce a tick afterwards, because the edge detector is cleared.

## Configuration
- `OBSTACLE_FOUR_MOTION_ANI_EN` defined: the animation counter and `sid` cycling are compiled in, as described above.
- Not defined: the counter is removed and `ctrl[1:0]` is tied to `2'b00`. All other behaviour is identical.

## Test plan
- Reset, then scan 3 frames with no `go`: `x0=640`, `y0=0`, `busy=0`, `wrap_cnt=0`; exactly 3 `frame_tick` pulses, with `x` held at 0 for 4 clocks per pixel.
- `go` with `speed=5`, `lane_y=200`: after ARM tick, `x0=640`, `y0=200`. After 3 further ticks, `x0=625`.
- `speed=15` from `x0=640`: after 42 ticks `x0=10`. The next tick wraps (`10<15`): `x0=640`, `wrap_cnt=1`; new `speed`/`lane_y` values applied to `wrap_cnt` 1 are latched.
- In RUN, assert `halt` and `go` together: PAUSE, with `x0` unchanged across 2 ticks. Release `halt` with `go=1`: RUN resumes and the next tick moves `x0` by `speed`.
- With `ANI_FRAMES=2` and the macro defined: `ctrl[1:0]` follows 0,0,1,1,2,2,3,3,0 over RUN ticks. Without the macro it stays 0. `color_sel=2'b10` gives `ctrl[4:3]=2'b10`.
- Assert `reset` in RUN with `wrap_cnt=3` while `fcond` is high: the next cycle shows reset values and no `frame_tick` until the next frame edge.
